// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: drives the instruction memory address and buffers fetched
// words in a small PC-tagged prefetch FIFO for decode. Optional halt-on-opcode: FETCH_HALT_EN.
module fetch_sequencer #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned INSTR_W     = 39,
  parameter int unsigned DEPTH       = 2,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_instr,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready,
  output logic               busy,
  output logic               halted
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full      = CntW'(DEPTH);
  localparam logic [CntW-1:0] AlmostFull = CntW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StStall, StHalted} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [PtrW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [INSTR_W-1:0] buf_instr_q [DEPTH];
  logic [ADDR_W-1:0]  buf_pc_q    [DEPTH];

  logic pop, push, halt_hit;

  assign pop  = out_valid & out_ready;
  assign push = (state_q == StFetch) & ((count_q < Full) | pop) & ~redirect_valid;

`ifdef FETCH_HALT_EN
  assign halt_hit = push & (mem_instr[INSTR_W-1 -: 6] == HALT_OPCODE);
  assign halted   = (state_q == StHalted);
`else
  logic unused_opcode;
  assign unused_opcode = ^(mem_instr[INSTR_W-1 -: 6] ^ HALT_OPCODE);
  assign halt_hit      = 1'b0;
  assign halted        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CntW'(push) - CntW'(pop);
    if (push) begin
      tail_d = tail_q + PtrW'(1);
      pc_d   = pc_q + ADDR_W'(1);
    end
    if (pop) head_d = head_q + PtrW'(1);

    unique case (state_q)
      StIdle: begin
        if (redirect_valid) pc_d = redirect_addr;
        else if (start)     state_d = StFetch;
      end
      StFetch: begin
        if (halt_hit)                                     state_d = StHalted;
        else if (push && !pop && count_q == AlmostFull)   state_d = StStall;
      end
      StStall:  if (pop) state_d = StFetch;
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase

    // Redirect outranks everything outside IDLE; a same-cycle pop is simply lost with the flush.
    if (redirect_valid && state_q != StIdle) begin
      state_d = StFetch;
      pc_d    = redirect_addr;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        buf_instr_q[tail_q] <= mem_instr;
        buf_pc_q[tail_q]    <= pc_q;
      end
    end
  end

  assign mem_addr  = pc_q;
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? buf_instr_q[head_q] : '0;
  assign out_pc    = out_valid ? buf_pc_q[head_q] : '0;
  assign busy      = (state_q == StFetch) | (state_q == StStall);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a behavioural 64x39 instruction memory.
// Halt checks follow FETCH_HALT_EN when the bench is built with it.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, redirect_valid, out_ready;
  logic [5:0]  redirect_addr, mem_addr, out_pc;
  logic [38:0] mem_instr, out_instr;
  logic        out_valid, busy, halted;
  logic [38:0] mem [64];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  assign mem_instr = mem[mem_addr];

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .mem_addr      (mem_addr),
    .mem_instr     (mem_instr),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_ready     (out_ready),
    .busy          (busy),
    .halted        (halted)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Advance one edge; outputs are settled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic redirect_to(input logic [5:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 39'(i);
    mem[3] = {6'b111111, 33'd3};
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; out_ready = 1'b0;
    #2;

    // Reset state
    do_reset();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr",  64'(mem_addr),  64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_halt",  64'(halted),    64'd0);
    check("rst_pc",    64'(out_pc),    64'd0);
    check("rst_instr", 64'(out_instr), 64'd0);

    // Streaming with out_ready high: first word two cycles after start
    out_ready = 1'b1;
    pulse_start();
    check("s1_busy",  64'(busy),      64'd1);
    check("s1_valid", 64'(out_valid), 64'd0);
`ifdef FETCH_HALT_EN
    for (int k = 0; k < 3; k++) begin
      step();
      check("halt_pc", 64'(out_pc), 64'(k));
    end
    step();
    check("halt_pc3",   64'(out_pc),    64'd3);
    check("halt_flag",  64'(halted),    64'd1);
    check("halt_busy",  64'(busy),      64'd0);
    check("halt_addr",  64'(mem_addr),  64'd4);
    step();
    check("halt_drain", 64'(out_valid), 64'd0);
    check("halt_frz",   64'(mem_addr),  64'd4);
    redirect_to(6'd10);
    check("hr_halt",  64'(halted),    64'd0);
    check("hr_busy",  64'(busy),      64'd1);
    check("hr_addr",  64'(mem_addr),  64'd10);
    step();
    check("hr_pc",    64'(out_pc),    64'd10);
    check("hr_valid", 64'(out_valid), 64'd1);
`else
    for (int k = 0; k < 6; k++) begin
      step();
      check("st_valid", 64'(out_valid), 64'd1);
      check("st_pc",    64'(out_pc),    64'(k));
      check("st_instr", 64'(out_instr), 64'(mem[k]));
      check("st_nohalt", 64'(halted),   64'd0);
    end
`endif

    // Wrap: redirect to 62 then expect 62, 63, 0, 1
    redirect_to(6'd62);
    check("wr_flush", 64'(out_valid), 64'd0);
    check("wr_addr",  64'(mem_addr),  64'd62);
    for (int k = 0; k < 4; k++) begin
      step();
      check("wr_pc", 64'(out_pc), 64'((62 + k) % 64));
    end

    // Backpressure: stall at two entries, then resume without loss
    do_reset();
    out_ready = 1'b0;
    pulse_start();
    step();
    step();
    step();
    check("bp_addr",  64'(mem_addr), 64'd2);
    check("bp_busy",  64'(busy),     64'd1);
    check("bp_pc0",   64'(out_pc),   64'd0);
    step();
    check("bp_hold",  64'(out_pc),   64'd0);
    check("bp_holdi", 64'(out_instr), 64'd0);
    check("bp_addr2", 64'(mem_addr), 64'd2);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      check("bp_pc", 64'(out_pc), 64'(k));
    end

    // Redirect in IDLE loads PC only; then flush while buffer holds 5,6
    do_reset();
    out_ready = 1'b0;
    redirect_to(6'd5);
    check("ri_busy",  64'(busy),      64'd0);
    check("ri_addr",  64'(mem_addr),  64'd5);
    check("ri_valid", 64'(out_valid), 64'd0);
    pulse_start();
    step();
    step();
    check("rf_pc5",   64'(out_pc),   64'd5);
    check("rf_addr",  64'(mem_addr), 64'd7);
    out_ready = 1'b1;
    redirect_to(6'd40);
    check("rf_flush", 64'(out_valid), 64'd0);
    check("rf_addr2", 64'(mem_addr),  64'd40);
    step();
    check("rf_pc40",  64'(out_pc),    64'd40);
    step();
    check("rf_pc41",  64'(out_pc),    64'd41);

    // Reset low during STALL with full buffer, other inputs active
    do_reset();
    out_ready = 1'b0;
    pulse_start();
    step();
    step();
    step();
    check("rs_full", 64'(out_valid), 64'd1);
    reset = 1'b0; start = 1'b1; redirect_valid = 1'b1; redirect_addr = 6'd20;
    step();
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0;
    check("rs_valid", 64'(out_valid), 64'd0);
    check("rs_addr",  64'(mem_addr),  64'd0);
    check("rs_busy",  64'(busy),      64'd0);
    check("rs_halt",  64'(halted),    64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
